// File: rtl/alu_uart_if.sv
// Byte-stream front-end for the bring-up ALU: assembles A/B/op/shamt from uart_rx, drives the ALU,
// and returns the result plus zero flag via uart_tx. Define ALU_UART_IF_CHECKSUM_EN to add an XOR byte.
module alu_uart_if #(
  parameter int unsigned BITS_SIZE  = 32,
  parameter int unsigned BITS_OP    = 4,
  parameter int unsigned BITS_SHAMT = 5,
  parameter int unsigned BITS_UART  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [BITS_UART-1:0]  i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  output logic [BITS_UART-1:0]  o_tx_data,
  output logic                  o_tx_start,
  output logic [BITS_SIZE-1:0]  o_data_a,
  output logic [BITS_SIZE-1:0]  o_data_b,
  output logic [BITS_OP-1:0]    o_op,
  output logic [BITS_SHAMT-1:0] o_alu_shamt,
  output logic                  o_flag_shamt,
  input  logic [BITS_SIZE-1:0]  i_alu_result,
  input  logic                  i_alu_zero,
  output logic                  o_busy
);

  localparam int unsigned NB = BITS_SIZE / BITS_UART;
`ifdef ALU_UART_IF_CHECKSUM_EN
  localparam int unsigned NTX = NB + 2;
`else
  localparam int unsigned NTX = NB + 1;
`endif
  localparam int unsigned CntW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned IdxW = $clog2(NTX + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(NB - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NTX - 1);

  typedef enum logic [2:0] {
    StRxA,
    StRxB,
    StRxOp,
    StRxShamt,
    StExec,
    StTxSend,
    StTxWait
  } state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [IdxW-1:0]        idx_q;
  logic [BITS_SIZE-1:0]   sh_a_q;
  logic [BITS_SIZE-1:0]   sh_b_q;
  logic [BITS_OP-1:0]     sh_op_q;
  logic [BITS_SIZE-1:0]   res_q;
  logic                   zero_q;

  logic [IdxW-1:0]        idx_next;
  logic [BITS_UART-1:0]   status_byte;
  logic [BITS_UART-1:0]   next_byte;

  assign idx_next    = idx_q + IdxW'(1);
  assign status_byte = {{(BITS_UART-1){1'b0}}, zero_q};
  assign o_busy      = !((state_q == StRxA) && (cnt_q == '0));

`ifdef ALU_UART_IF_CHECKSUM_EN
  logic [BITS_UART-1:0] csum;

  always_comb begin
    csum = status_byte;
    for (int i = 0; i < NB; i++) begin
      csum = csum ^ res_q[i*BITS_UART +: BITS_UART];
    end
  end
`endif

  // Byte loaded on the next S_TX_SEND; byte 0 comes straight from the ALU in S_EXEC.
  always_comb begin
    next_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx_next == IdxW'(i)) begin
        next_byte = res_q[i*BITS_UART +: BITS_UART];
      end
    end
    if (idx_next == IdxW'(NB)) begin
      next_byte = status_byte;
    end
`ifdef ALU_UART_IF_CHECKSUM_EN
    if (idx_next == IdxW'(NB + 1)) begin
      next_byte = csum;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= StRxA;
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_a_q       <= '0;
      sh_b_q       <= '0;
      sh_op_q      <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_data_a     <= '0;
      o_data_b     <= '0;
      o_op         <= '0;
      o_alu_shamt  <= '0;
      o_flag_shamt <= 1'b0;
    end else begin
      case (state_q)
        StRxA: begin
          if (i_rx_done) begin
            for (int i = 0; i < NB; i++) begin
              if (cnt_q == CntW'(i)) sh_a_q[i*BITS_UART +: BITS_UART] <= i_rx_data;
            end
            if (cnt_q == CntLast) begin
              cnt_q   <= '0;
              state_q <= StRxB;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StRxB: begin
          if (i_rx_done) begin
            for (int i = 0; i < NB; i++) begin
              if (cnt_q == CntW'(i)) sh_b_q[i*BITS_UART +: BITS_UART] <= i_rx_data;
            end
            if (cnt_q == CntLast) begin
              cnt_q   <= '0;
              state_q <= StRxOp;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StRxOp: begin
          if (i_rx_done) begin
            sh_op_q <= i_rx_data[BITS_OP-1:0];
            state_q <= StRxShamt;
          end
        end
        StRxShamt: begin
          // All ALU inputs switch on this one edge so the ALU never sees a half-built frame.
          if (i_rx_done) begin
            o_data_a     <= sh_a_q;
            o_data_b     <= sh_b_q;
            o_op         <= sh_op_q;
            o_alu_shamt  <= i_rx_data[BITS_SHAMT-1:0];
            o_flag_shamt <= i_rx_data[BITS_UART-1];
            state_q      <= StExec;
          end
        end
        StExec: begin
          res_q      <= i_alu_result;
          zero_q     <= i_alu_zero;
          idx_q      <= '0;
          o_tx_data  <= i_alu_result[BITS_UART-1:0];
          o_tx_start <= 1'b1;
          state_q    <= StTxSend;
        end
        StTxSend: begin
          o_tx_start <= 1'b0;
          state_q    <= StTxWait;
        end
        StTxWait: begin
          if (i_tx_done) begin
            if (idx_q == IdxLast) begin
              idx_q   <= '0;
              state_q <= StRxA;
            end else begin
              idx_q      <= idx_next;
              o_tx_data  <= next_byte;
              o_tx_start <= 1'b1;
              state_q    <= StTxSend;
            end
          end
        end
        default: state_q <= StRxA;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_if.sv
// Directed bench for alu_uart_if: table of frames with hand-computed results, plus reset corners.
module tb_alu_uart_if;

  localparam int NB = 4;
`ifdef ALU_UART_IF_CHECKSUM_EN
  localparam int RESP = NB + 2;
`else
  localparam int RESP = NB + 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [3:0]  op;
  logic [4:0]  alu_shamt;
  logic        flag_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;

  always #5 clk = ~clk;

  alu_uart_if dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_tx_done    (tx_done),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_data_a     (data_a),
    .o_data_b     (data_b),
    .o_op         (op),
    .o_alu_shamt  (alu_shamt),
    .o_flag_shamt (flag_shamt),
    .i_alu_result (alu_result),
    .i_alu_zero   (alu_zero),
    .o_busy       (busy)
  );

  // Stand-in ALU: ADD, SUB, XOR for every other op.
  always_comb begin
    case (op)
      4'h0:    alu_result = data_a + data_b;
      4'h1:    alu_result = data_a - data_b;
      default: alu_result = data_a ^ data_b;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  always @(posedge clk) if (tx_start) n_starts++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op_byte;
    logic [7:0]  sh_byte;
    logic [31:0] res;
    logic        zero;
    logic [3:0]  exp_op;
    logic        exp_flag;
    logic [4:0]  exp_shamt;
    int          stall;
    bit          inject;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0]  exp_b[RESP];
    logic [7:0]  held;
    logic [7:0]  x;
    logic [31:0] tmp;
    bit          stable;
    int          t;
    x = 8'h0;
    for (int k = 0; k < NB; k++) begin
      tmp = v.res >> (8 * k);
      exp_b[k] = tmp[7:0];
      x = x ^ tmp[7:0];
    end
    exp_b[NB] = {7'b0, v.zero};
    x = x ^ exp_b[NB];
    if (RESP > NB + 1) exp_b[RESP-1] = x;
    n_starts = 0;
    for (int k = 0; k < NB; k++) begin
      tmp = v.a >> (8 * k);
      send_byte(tmp[7:0]);
    end
    for (int k = 0; k < NB; k++) begin
      tmp = v.b >> (8 * k);
      send_byte(tmp[7:0]);
    end
    send_byte(v.op_byte);
    // Last byte: drive it, then observe right after the sampling edge and one cycle later.
    rx_data = v.sh_byte;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    check("data_a", data_a, v.a);
    check("data_b", data_b, v.b);
    check("op", {28'h0, op}, {28'h0, v.exp_op});
    check("flag_shamt", {31'h0, flag_shamt}, {31'h0, v.exp_flag});
    check("alu_shamt", {27'h0, alu_shamt}, {27'h0, v.exp_shamt});
    check("tx_start_early", {31'h0, tx_start}, 32'h0);
    @(negedge clk);
    check("tx_start_latency", {31'h0, tx_start}, 32'h1);
    for (int k = 0; k < RESP; k++) begin
      t = 0;
      while (!tx_start && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!tx_start) check("tx_start_timeout", 32'h0, 32'h1);
      check($sformatf("tx_byte%0d", k), {24'h0, tx_data}, {24'h0, exp_b[k]});
      held   = tx_data;
      stable = 1'b1;
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk);
        if (tx_data !== held || tx_start !== 1'b0) stable = 1'b0;
        if (v.inject && k == 0 && s == 10) begin
          rx_data = 8'hAA;
          rx_done = 1'b1;
        end else begin
          rx_done = 1'b0;
        end
      end
      rx_done = 1'b0;
      if (v.stall > 1) check($sformatf("tx_hold%0d", k), {31'h0, stable}, 32'h1);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    check("start_count", n_starts, RESP);
    check("busy_after_frame", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    check("no_extra_start", n_starts, RESP);
  endtask

  initial begin
    vec_t v;
    //          a             b             op     sh     res           zero  eop   flag  shamt  stall inj
    vecs[0] = '{32'h00000002, 32'h00000001, 8'h00, 8'h00, 32'h00000003, 1'b0, 4'h0, 1'b0, 5'h00, 2,  1'b0};
    vecs[1] = '{32'h00000005, 32'h00000005, 8'h01, 8'h00, 32'h00000000, 1'b1, 4'h1, 1'b0, 5'h00, 2,  1'b0};
    vecs[2] = '{32'h00000001, 32'h00000002, 8'h09, 8'h9F, 32'h00000003, 1'b0, 4'h9, 1'b1, 5'h1F, 3,  1'b0};
    vecs[3] = '{32'h12345678, 32'h11111111, 8'h00, 8'h05, 32'h23456789, 1'b0, 4'h0, 1'b0, 5'h05, 50, 1'b1};
    vecs[4] = '{32'h00000010, 32'h00000003, 8'hF1, 8'h60, 32'h0000000D, 1'b0, 4'h1, 1'b0, 5'h00, 1,  1'b0};

    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_a", data_a, 32'h0);
    check("rst_data_b", data_b, 32'h0);
    check("rst_op_shamt", {23'h0, op, alu_shamt}, 32'h0);
    check("rst_flag_start_busy", {29'h0, flag_shamt, tx_start, busy}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    rst_n    = 1'b1;
    n_starts = 0;
    tx_done  = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_no_start", n_starts, 0);
    check("post_rst_busy", {31'h0, busy}, 32'h0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort after 6 bytes; the next frame must carry no residue.
    for (int k = 0; k < 6; k++) send_byte(8'hEE);
    check("busy_mid_frame", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_data_a", data_a, 32'h0);
    @(negedge clk);
    v = '{32'h00000007, 32'h00000003, 8'h00, 8'h00, 32'h0000000A, 1'b0, 4'h0, 1'b0, 5'h00, 2, 1'b0};
    run_vec(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_uart_if.md
Name: alu_uart_if

Overview:
Sequential front-end that drives the datapath ALU from a byte stream and returns the result.
- Assembles operands A and B, op code and shift control from bytes delivered by the UART receiver.
- Presents them to the alu block atomically and latches its result.
- Serialises the result and zero flag to the UART transmitter through a start/done handshake.
- Sits between uart_rx/uart_tx and alu in the ALU bring-up top level.

Parameters:
BITS_SIZE, 32, operand/result width (multiple of BITS_UART)
BITS_OP, 4, ALU op code width
BITS_SHAMT, 5, shift amount width
BITS_UART, 8, UART byte width

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  synchronous reset, active-low
i_rx_data  in  BITS_UART  received byte, valid when i_rx_done=1
i_rx_done  in  1  one-cycle strobe from uart_rx
i_tx_done  in  1  one-cycle strobe from uart_tx, byte fully sent
o_tx_data  out  BITS_UART  byte to transmit
o_tx_start  out  1  one-cycle start pulse to uart_tx
o_data_a  out  BITS_SIZE  ALU operand A
o_data_b  out  BITS_SIZE  ALU operand B
o_op  out  BITS_OP  ALU op code
o_alu_shamt  out  BITS_SHAMT  ALU shift amount
o_flag_shamt  out  1  ALU shamt select
i_alu_result  in  BITS_SIZE  ALU result (combinational from o_* operands)
i_alu_zero  in  1  ALU zero flag
o_busy  out  1  high outside S_RX_A with byte count 0

Behaviour:
- Clock and reset: one clock domain, i_clk. i_reset is synchronous, active-low, sampled on the rising edge.
- Reset values: every output 0, state S_RX_A, byte counter 0, shadow and result registers 0. A reset mid-frame or mid-transmission discards all partial data. o_tx_start is never asserted in the cycle following reset.
- RX frame: NB = BITS_SIZE/BITS_UART bytes per operand (4 at default). Frame layout:
  - A, NB bytes, LSB first
  - B, NB bytes, LSB first
  - OP byte: bits[BITS_OP-1:0] = op; upper bits ignored
  - SHAMT byte: bit7 = flag_shamt, bits[BITS_SHAMT-1:0] = shamt
- Per state:
  - S_RX_A / S_RX_B: on each i_rx_done, store the byte into shadow reg slice [cnt]; cnt increments. At cnt=NB-1, cnt resets to 0 and the FSM advances.
  - S_RX_OP: on i_rx_done, capture op, go to S_RX_SHAMT.
  - S_RX_SHAMT: on i_rx_done, capture shamt/flag, go to S_EXEC. On the same edge, load o_data_a, o_data_b, o_op, o_alu_shamt and o_flag_shamt from the shadow regs, all together. ALU inputs never change mid-frame.
  - S_EXEC (1 cycle): at the end of the cycle, latch i_alu_result into res_reg and i_alu_zero into zero_reg; go to S_TX_SEND with tx index 0.
  - S_TX_SEND (1 cycle): o_tx_start=1, o_tx_data=byte[idx]; go to S_TX_WAIT.
  - S_TX_WAIT: o_tx_start=0, o_tx_data held. On i_tx_done, idx increments; the FSM returns to S_TX_SEND, or to S_RX_A when the last byte is done.
- TX byte order: res_reg bytes LSB first, then the status byte {7'b0, zero_reg}. NB+1 bytes total.
- Latency: the i_rx_done of the SHAMT byte at cycle N produces o_tx_start high at cycle N+2.
- i_rx_done in S_EXEC/S_TX_*: byte dropped, no state change.
- i_tx_done outside S_TX_WAIT: ignored.
- ALU output registers hold their values until the next frame completes.
- Error handling: none. A missing byte stalls the FSM indefinitely until reset.

Optional Feature:
ALU_UART_IF_CHECKSUM_EN
- Defined: after the status byte, one extra byte is sent, equal to the XOR of all preceding TX bytes of that response (NB+2 bytes total).
- Undefined: the response is exactly NB+1 bytes and no checksum logic is synthesised.

Test Plan:
1. Reset low 3 cycles, then high -> all outputs 0, o_busy=0, no o_tx_start.
2. RX 02 00 00 00 | 01 00 00 00 | 00 | 00 with real alu (ADD) -> o_data_a=2, o_data_b=1, o_op=0; o_tx_start 2 cycles after the last rx_done. TX 03 00 00 00 00. With CHECKSUM_EN, a sixth byte 03 follows.
3. A=5, B=5, op=01 (SUB) -> TX 00 00 00 00 01 (zero flag set).
4. SHAMT byte 9F, op=09 -> o_flag_shamt=1 and o_alu_shamt=5'b11111, both updated on the same edge as o_op.
5. Stall i_tx_done 50 cycles after each start; inject i_rx_done=1 with byte AA during TX -> o_tx_data held stable, exactly one o_tx_start per byte, AA absent from the next frame.
6. Assert reset after 6 RX bytes, then send a full new frame A=7, B=3, op=00 -> TX 0A 00 00 00 00 (no residue from the aborted frame).
